// File: rtl/alu_seq.sv
// Sequential ALU: accept a request, execute (one cycle, or WIDTH cycles of shift-add
// multiply when ALU_SEQ_MUL_EN is defined), then hold the result until it is consumed.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [3:0]       func,
   input  logic             acc_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);
   localparam int SW = $clog2(WIDTH);

   localparam logic [3:0] F_ADD = 4'b0000;
   localparam logic [3:0] F_SUB = 4'b0001;
   localparam logic [3:0] F_AND = 4'b0100;
   localparam logic [3:0] F_OR  = 4'b0101;
   localparam logic [3:0] F_XOR = 4'b0110;
   localparam logic [3:0] F_SLL = 4'b1000;
   localparam logic [3:0] F_SRL = 4'b1001;
   localparam logic [3:0] F_SRA = 4'b1010;

`ifdef ALU_SEQ_MUL_EN
   localparam logic [3:0] F_MUL = 4'b0011;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD, S_MUL} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;
`endif

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [3:0]       func_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] result_reg;
   logic [3:0]       flags_reg;
   logic             out_valid_reg;
   logic             in_ready_reg;

   logic [WIDTH-1:0] a_next;

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign flags     = flags_reg;

   assign a_next = acc_sel ? acc_reg : op_a;

   function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                           input logic v);
      return {(r == '0), r[WIDTH-1], c, v};
   endfunction

   // Single-cycle datapath
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic [WIDTH-1:0]   b_op;
   logic [WIDTH:0]     add_ext;
   logic               cin_msb;
   logic [SW-1:0]      shamt;
   logic [2*WIDTH-1:0] shl_ext;
   logic [2*WIDTH-1:0] srl_ext;
   logic [2*WIDTH-1:0] sra_ext;

   always_comb begin
      shamt   = b_reg[SW-1:0];
      b_op    = (func_reg == F_SUB) ? ~b_reg : b_reg;
      add_ext = {1'b0, a_reg} + {1'b0, b_op} + {{WIDTH{1'b0}}, (func_reg == F_SUB)};
      cin_msb = a_reg[WIDTH-1] ^ b_op[WIDTH-1] ^ add_ext[WIDTH-1];
      // Shifting within a double-width window leaves the last bit shifted out
      // sitting right next to the result, so C falls out of a fixed bit position.
      shl_ext = {{WIDTH{1'b0}}, a_reg} << shamt;
      srl_ext = {a_reg, {WIDTH{1'b0}}} >> shamt;
      sra_ext = $signed({a_reg, {WIDTH{1'b0}}}) >>> shamt;

      alu_res = a_reg;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (func_reg)
         F_ADD, F_SUB: begin
            alu_res = add_ext[WIDTH-1:0];
            alu_c   = add_ext[WIDTH];
            alu_v   = cin_msb ^ add_ext[WIDTH];
         end
         F_AND: alu_res = a_reg & b_reg;
         F_OR:  alu_res = a_reg | b_reg;
         F_XOR: alu_res = a_reg ^ b_reg;
         F_SLL: begin
            alu_res = shl_ext[WIDTH-1:0];
            alu_c   = shl_ext[WIDTH];
         end
         F_SRL: begin
            alu_res = srl_ext[2*WIDTH-1:WIDTH];
            alu_c   = srl_ext[WIDTH-1];
         end
         F_SRA: begin
            alu_res = sra_ext[2*WIDTH-1:WIDTH];
            alu_c   = sra_ext[WIDTH-1];
         end
         default: alu_res = a_reg;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   // Shift-add multiplier: one bit of B per cycle, multiplicand walks left
   logic [2*WIDTH-1:0] mcand_reg;
   logic [2*WIDTH-1:0] prod_reg;
   logic [WIDTH-1:0]   mb_reg;
   logic [SW-1:0]      cnt_reg;
   logic [2*WIDTH-1:0] prod_next;

   assign prod_next = prod_reg + (mb_reg[0] ? mcand_reg : '0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         func_reg      <= '0;
         acc_reg       <= '0;
         result_reg    <= '0;
         flags_reg     <= 4'b1000;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
         mcand_reg     <= '0;
         prod_reg      <= '0;
         mb_reg        <= '0;
         cnt_reg       <= '0;
`endif
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (in_valid) begin
                  a_reg        <= a_next;
                  b_reg        <= op_b;
                  func_reg     <= func;
                  in_ready_reg <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                  if (func == F_MUL) begin
                     mcand_reg <= {{WIDTH{1'b0}}, a_next};
                     prod_reg  <= '0;
                     mb_reg    <= op_b;
                     cnt_reg   <= '0;
                     state_reg <= S_MUL;
                  end else begin
                     state_reg <= S_EXEC;
                  end
`else
                  state_reg    <= S_EXEC;
`endif
               end
            end
            S_EXEC: begin
               result_reg    <= alu_res;
               flags_reg     <= mk_flags(alu_res, alu_c, alu_v);
               out_valid_reg <= 1'b1;
               state_reg     <= S_HOLD;
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
               prod_reg  <= prod_next;
               mcand_reg <= mcand_reg << 1;
               mb_reg    <= mb_reg >> 1;
               cnt_reg   <= cnt_reg + 1'b1;
               if (cnt_reg == SW'(WIDTH - 1)) begin
                  result_reg    <= prod_next[WIDTH-1:0];
                  flags_reg     <= mk_flags(prod_next[WIDTH-1:0],
                                            |prod_next[2*WIDTH-1:WIDTH], 1'b0);
                  out_valid_reg <= 1'b1;
                  state_reg     <= S_HOLD;
               end
            end
`endif
            S_HOLD: begin
               if (out_ready) begin
                  acc_reg       <= result_reg;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= S_IDLE;
               end
            end
            default: begin
               state_reg     <= S_IDLE;
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
            end
         endcase
      end
   end
endmodule
